// File: rtl/stream_pkg.sv
// Shared types for the stream skid register: occupancy state of the two-slot buffer.
package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/stream_skid_register.sv
// Two-slot valid/ready skid register cutting both forward and backward paths.
// Optional stall counter enabled by macro STREAM_SKID_REGISTER_STALL_CNT_EN.
module stream_skid_register
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  skid_state_e           state_q;
  logic                  valid_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  push;
  logic                  pop;

  assign push    = valid_i & ready_q;
  assign pop     = valid_q & ready_i;
  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = main_q;

  // valid/ready are kept as dedicated flops alongside the state so no output
  // depends on any input through logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (clr_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_q  <= data_i;
            state_q <= HALF;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        HALF: begin
          if (push && pop) begin
            main_q <= data_i;
          end else if (push) begin
            skid_q  <= data_i;
            state_q <= FULL;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= HALF;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_skid_register.sv
// Self-checking bench for stream_skid_register against a queue-based reference model.
// Stall counter checks enabled when STREAM_SKID_REGISTER_STALL_CNT_EN is defined.
module tb_stream_skid_register;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_in;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] data_out;
`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int unsigned exp_stall;
`endif

  int unsigned n_checks;
  int unsigned n_pass;
  bit [7:0]    mq[$];

  stream_skid_register #(.DATA_WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (clr),
    .valid_i (valid_in),
    .ready_o (ready_out),
    .data_i  (data_in),
    .valid_o (valid_out),
    .ready_i (ready_in),
    .data_o  (data_out)
`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the queue model, compare after the edge.
  task automatic step(input logic r_st, input logic c, input logic v,
                      input logic [7:0] d, input logic r);
    bit do_push, do_pop, was_valid;
    rst = r_st; clr = c; valid_in = v; data_in = d; ready_in = r;
    was_valid = (mq.size() > 0);
    do_push   = v && (mq.size() < 2);
    do_pop    = was_valid && r;
    @(posedge clk);
    if (r_st || c) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
    end
`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
    if (r_st || c) exp_stall = 0;
    else if (was_valid && !r && exp_stall < 16'hFFFF) exp_stall++;
`endif
    #1;
    check("valid_o", valid_out, (mq.size() > 0));
    check("ready_o", ready_out, (mq.size() < 2));
    if (mq.size() > 0) check("data_o", data_out, mq[0]);
    if (r_st) check("data_o_rst", data_out, 0);
`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
    check("stall_cnt_o", stall_cnt, exp_stall);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
    exp_stall = 0;
`endif
    rst = 1'b1; clr = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;

    // Reset state
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);

    // Single beat with 1-cycle latency
    step(0, 0, 1, 8'hA5, 1);
    check("single_valid", valid_out, 1);
    check("single_data", data_out, 8'hA5);
    step(0, 0, 0, 8'h00, 1);
    check("single_drain", valid_out, 0);

    // Streaming 0..15 at full rate
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 8'(i), 1);
      check("stream_data", data_out, i);
      check("stream_ready", ready_out, 1);
    end
    step(0, 0, 0, 8'h00, 1);

    // Backpressure: third beat held upstream while FULL
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    check("bp_full_ready", ready_out, 0);
    step(0, 0, 1, 8'h33, 0);
    check("bp_hold_data", data_out, 8'h11);
    step(0, 0, 1, 8'h33, 1);
    check("bp_out2", data_out, 8'h22);
    step(0, 0, 1, 8'h33, 1);
    check("bp_out3", data_out, 8'h33);
    step(0, 0, 0, 8'h00, 1);
    check("bp_drain", valid_out, 0);

    // Flush from FULL with a colliding push
    step(0, 0, 1, 8'h01, 0);
    step(0, 0, 1, 8'h02, 0);
    step(0, 1, 1, 8'h03, 1);
    check("flush_valid", valid_out, 0);
    check("flush_ready", ready_out, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 8'h00, 1);
      check("flush_no_03", valid_out, 0);
    end

    // Reset mid-operation
    step(0, 0, 1, 8'h44, 0);
    step(0, 0, 1, 8'h55, 0);
    step(1, 0, 0, 8'h00, 0);
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_data", data_out, 0);
    step(0, 0, 0, 8'h00, 0);
    check("post_rst_ready", ready_out, 1);

    // Randomized traffic with occasional flush/reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
           1'($urandom), 8'($urandom), 1'($urandom));
    end

`ifdef STREAM_SKID_REGISTER_STALL_CNT_EN
    // Stall counter saturation and clear
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h77, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 8'h00, 0);
    check("stall_sat", stall_cnt, 16'hFFFF);
    step(0, 1, 0, 8'h00, 0);
    check("stall_clr", stall_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
